// File: rtl/sync_fifo_lvl_pkg.sv
// sync_fifo_lvl_pkg: shared types and default sizing for the single-clock
// level-reporting FIFO (sync_fifo_lvl) and its storage sub-module.
package sync_fifo_lvl_pkg;

  // Default geometry: 8-bit words, 16 entries.
  localparam int DSIZE_DEF = 8;
  localparam int ASIZE_DEF = 4;

  // Registered status flags, all derived from the next occupancy.
  typedef struct packed {
    logic wfull;
    logic rempty;
    logic almost_full;
    logic almost_empty;
  } fifo_flags_t;

  // Flag values while in reset: empty, not full, below any almost-full level.
  localparam fifo_flags_t FLAGS_RESET = '{
    wfull:        1'b0,
    rempty:       1'b1,
    almost_full:  1'b0,
    almost_empty: 1'b1
  };

endpackage

// File: rtl/sync_fifo_defs.vh
// sync_fifo_defs.vh: occupancy arithmetic and flag-compare helpers shared by
// the sync FIFO family (single- and multi-channel variants).
// The macro section is guarded; the localparam section is meant to be
// included once inside the body of a module that has an ASIZE parameter.
`ifndef SYNC_FIFO_DEFS_VH
`define SYNC_FIFO_DEFS_VH

// Depth and pointer width derived from the address width.
`define SFL_DEPTH(asize)  (1 << (asize))
`define SFL_PTR_W(asize)  ((asize) + 1)

// Next occupancy: one in for an accepted write, one out for an accepted read.
`define SFL_COUNT_NEXT(cnt, wr, rd, w) ((cnt) + w'(wr) - w'(rd))

// Flag compares against an occupancy value of width w.
`define SFL_IS_FULL(cnt, depth, w)  ((cnt) == w'(depth))
`define SFL_IS_EMPTY(cnt, w)        ((cnt) == w'(0))
`define SFL_AT_LEAST(cnt, thresh)   ((cnt) >= (thresh))
`define SFL_AT_MOST(cnt, thresh)    ((cnt) <= (thresh))

`endif

// Geometry of the including module.
localparam int DEPTH = `SFL_DEPTH(ASIZE);
localparam int PTR_W = `SFL_PTR_W(ASIZE);

// File: rtl/sync_fifo_mem.sv
// sync_fifo_mem: dual-port storage for sync_fifo_lvl.
// Synchronous write port, asynchronous (combinational) read port.
module sync_fifo_mem #(
  parameter int DSIZE = 8,
  parameter int ASIZE = 4
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [ASIZE-1:0] i_waddr,
  input  logic [DSIZE-1:0] i_wdata,
  input  logic [ASIZE-1:0] i_raddr,
  output logic [DSIZE-1:0] o_rdata
);

  localparam int DEPTH = 1 << ASIZE;

  logic [DSIZE-1:0] r_mem [DEPTH];

  // Write port: store the word on an accepted write.
  // NOTE: storage has no reset; the pointers alone decide which entries are
  // valid, and leaving the array unreset lets it map onto RAM primitives.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Read port: the addressed entry, combinationally.
  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/sync_fifo_lvl.sv
// sync_fifo_lvl: single-clock FIFO with registered full/empty flags, fill
// level, programmable almost-full/almost-empty levels and sticky
// overflow/underflow flags.
// Optional build macro SYNC_FIFO_FWFT_EN selects first-word-fall-through
// reads (rdata shows the head entry whenever not empty); without it, rdata
// is registered on each accepted read.
module sync_fifo_lvl
  import sync_fifo_lvl_pkg::*;
#(
  parameter int DSIZE = DSIZE_DEF,
  parameter int ASIZE = ASIZE_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DSIZE-1:0] wdata,
  input  logic             winc,
  input  logic             rinc,
  input  logic [ASIZE:0]   afull_thresh,
  input  logic [ASIZE:0]   aempty_thresh,
  input  logic             err_clr,
  output logic [DSIZE-1:0] rdata,
  output logic             wfull,
  output logic             rempty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [ASIZE:0]   count,
  output logic             overflow,
  output logic             underflow
);

  `include "sync_fifo_defs.vh"

  // Binary pointers with a wrap bit above the address bits.
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [PTR_W-1:0] r_count;
  logic [PTR_W-1:0] w_count_next;

  fifo_flags_t      r_flags;
  fifo_flags_t      w_flags_next;

  logic             r_overflow;
  logic             r_underflow;

  logic             w_wr_ok;
  logic             w_rd_ok;
  logic             w_set_overflow;
  logic             w_set_underflow;
  logic [DSIZE-1:0] w_mem_rdata;

  // Requests are accepted only against the registered flags, so a full FIFO
  // with both requests high reads only and an empty one writes only.
  assign w_wr_ok = winc & ~r_flags.wfull;
  assign w_rd_ok = rinc & ~r_flags.rempty;

  // A rejected request is an error but otherwise has no effect.
  assign w_set_overflow  = winc & r_flags.wfull;
  assign w_set_underflow = rinc & r_flags.rempty;

  assign w_count_next = `SFL_COUNT_NEXT(r_count, w_wr_ok, w_rd_ok, PTR_W);

  // Storage: written on accepted writes, read at the head address.
  sync_fifo_mem #(
    .DSIZE (DSIZE),
    .ASIZE (ASIZE)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_wr_ok),
    .i_waddr (r_wptr[ASIZE-1:0]),
    .i_wdata (wdata),
    .i_raddr (r_rptr[ASIZE-1:0]),
    .o_rdata (w_mem_rdata)
  );

  // Advance the write and read pointers on accepted requests.
  // NOTE: state registers use non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_wr_ok) begin
        r_wptr <= r_wptr + PTR_W'(1);
      end
      if (w_rd_ok) begin
        r_rptr <= r_rptr + PTR_W'(1);
      end
    end
  end

  // Derive every flag from the next occupancy and the current thresholds.
  // A threshold of 0 makes almost_full true and one of DEPTH or more makes
  // almost_empty true, both falling out of the plain compares.
  always_comb begin
    // NOTE: a full default first keeps every field assigned on every path,
    // so no latch can be inferred if branches are added later.
    w_flags_next              = FLAGS_RESET;
    w_flags_next.wfull        = `SFL_IS_FULL(w_count_next, DEPTH, PTR_W);
    w_flags_next.rempty       = `SFL_IS_EMPTY(w_count_next, PTR_W);
    w_flags_next.almost_full  = `SFL_AT_LEAST(w_count_next, afull_thresh);
    w_flags_next.almost_empty = `SFL_AT_MOST(w_count_next, aempty_thresh);
  end

  // Register occupancy and flags together so they always agree.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
      r_flags <= FLAGS_RESET;
    end else begin
      r_count <= w_count_next;
      r_flags <= w_flags_next;
    end
  end

  // Sticky error flags: a new error in the same cycle as a clear wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_overflow  <= w_set_overflow  | (r_overflow  & ~err_clr);
      r_underflow <= w_set_underflow | (r_underflow & ~err_clr);
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  // Head entry shown straight from the asynchronous read port; it is only
  // meaningful while the FIFO is not empty.
  assign rdata = w_mem_rdata;
`else
  logic [DSIZE-1:0] r_rdata;

  // Capture the head entry on an accepted read and hold it until the next.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdata <= '0;
    end else if (w_rd_ok) begin
      r_rdata <= w_mem_rdata;
    end
  end

  assign rdata = r_rdata;
`endif

  assign count        = r_count;
  assign wfull        = r_flags.wfull;
  assign rempty       = r_flags.rempty;
  assign almost_full  = r_flags.almost_full;
  assign almost_empty = r_flags.almost_empty;
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

endmodule

// File: tb/tb_sync_fifo_lvl.sv
// tb_sync_fifo_lvl: self-checking bench for sync_fifo_lvl (DSIZE=8, ASIZE=4).
// A queue holds the words the bench expects to come out; a small occupancy
// and error-flag model supplies the expected flags after every clock.
module tb_sync_fifo_lvl;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 1 << AW;

  logic          clk;
  logic          rst;
  logic [DW-1:0] wdata;
  logic          winc;
  logic          rinc;
  logic [AW:0]   afull_thresh;
  logic [AW:0]   aempty_thresh;
  logic          err_clr;
  logic [DW-1:0] rdata;
  logic          wfull;
  logic          rempty;
  logic          almost_full;
  logic          almost_empty;
  logic [AW:0]   count;
  logic          overflow;
  logic          underflow;

  sync_fifo_lvl #(
    .DSIZE (DW),
    .ASIZE (AW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .wdata         (wdata),
    .winc          (winc),
    .rinc          (rinc),
    .afull_thresh  (afull_thresh),
    .aempty_thresh (aempty_thresh),
    .err_clr       (err_clr),
    .rdata         (rdata),
    .wfull         (wfull),
    .rempty        (rempty),
    .almost_full   (almost_full),
    .almost_empty  (almost_empty),
    .count         (count),
    .overflow      (overflow),
    .underflow     (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard and reference model.
  logic [DW-1:0] sb_q[$];
  int            m_count;
  logic          m_ovf;
  logic          m_unf;
  logic [DW-1:0] m_rdata;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Compare every DUT output against the model.
  task automatic check_state(input string tag);
    check({tag, ".count"},  32'(count),        32'(m_count));
    check({tag, ".wfull"},  32'(wfull),        32'(m_count == DEPTH));
    check({tag, ".rempty"}, 32'(rempty),       32'(m_count == 0));
    check({tag, ".afull"},  32'(almost_full),  32'(m_count >= int'(afull_thresh)));
    check({tag, ".aempty"}, 32'(almost_empty), 32'(m_count <= int'(aempty_thresh)));
    check({tag, ".ovf"},    32'(overflow),     32'(m_ovf));
    check({tag, ".unf"},    32'(underflow),    32'(m_unf));
`ifdef SYNC_FIFO_FWFT_EN
    if (m_count > 0) begin
      check({tag, ".head"}, 32'(rdata), 32'(sb_q[0]));
    end
`else
    check({tag, ".rdata"}, 32'(rdata), 32'(m_rdata));
`endif
  endtask

  // One clock of stimulus, entered and left at a falling edge.
  task automatic cycle(input string tag, input logic w, input logic r,
                       input logic [DW-1:0] d, input logic clr);
    logic acc_w;
    logic acc_r;
    winc    = w;
    rinc    = r;
    wdata   = d;
    err_clr = clr;
    acc_w   = w && (m_count < DEPTH);
    acc_r   = r && (m_count > 0);
    m_ovf   = (w && (m_count == DEPTH)) || (m_ovf && !clr);
    m_unf   = (r && (m_count == 0))     || (m_unf && !clr);
    if (acc_r) m_rdata = sb_q.pop_front();
    if (acc_w) sb_q.push_back(d);
    m_count = m_count + int'(acc_w) - int'(acc_r);
    @(posedge clk);
    @(negedge clk);
    winc    = 1'b0;
    rinc    = 1'b0;
    err_clr = 1'b0;
    check_state(tag);
  endtask

  task automatic model_reset();
    sb_q.delete();
    m_count = 0;
    m_ovf   = 1'b0;
    m_unf   = 1'b0;
    m_rdata = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int writes;
    int pre;
    logic w;
    logic r;

    rst           = 1'b1;
    winc          = 1'b0;
    rinc          = 1'b0;
    wdata         = '0;
    err_clr       = 1'b0;
    afull_thresh  = 5'd12;
    aempty_thresh = 5'd2;
    model_reset();

    // Reset state, held and after release.
    repeat (2) @(negedge clk);
    check_state("reset");
    rst = 1'b0;
    @(negedge clk);
    check_state("post_reset");

    // Fill with 0x00..0x0F, then overflow, clear, and set-wins-over-clear.
    for (int i = 0; i < DEPTH; i++) cycle("fill", 1'b1, 1'b0, DW'(i), 1'b0);
    check("fill.count16", 32'(count), 32'd16);
    cycle("ovf", 1'b1, 1'b0, 8'hEE, 1'b0);
    cycle("ovf_clr", 1'b0, 1'b0, 8'h00, 1'b1);
    cycle("ovf_setwins", 1'b1, 1'b0, 8'hEF, 1'b1);
    cycle("ovf_clr2", 1'b0, 1'b0, 8'h00, 1'b1);

    // Drain in order, then underflow and clear.
    for (int i = 0; i < DEPTH; i++) cycle("drain", 1'b0, 1'b1, 8'h00, 1'b0);
    check("drain.last", 32'(rdata), 32'h0F);
    cycle("unf", 1'b0, 1'b1, 8'h00, 1'b0);
    cycle("unf_clr", 1'b0, 1'b0, 8'h00, 1'b1);

    // Simultaneous access at count 5: level steady, order preserved.
    for (int i = 0; i < 5; i++)  cycle("sim_pre", 1'b1, 1'b0, DW'(8'h20 + i), 1'b0);
    for (int i = 0; i < 10; i++) cycle("sim5", 1'b1, 1'b1, DW'(8'h30 + i), 1'b0);
    check("sim5.count", 32'(count), 32'd5);
    // Full with both high: read only.
    while (m_count < DEPTH) cycle("sim_fill", 1'b1, 1'b0, DW'($urandom), 1'b0);
    cycle("sim_full", 1'b1, 1'b1, 8'h77, 1'b0);
    check("sim_full.count", 32'(count), 32'd15);
    // Empty with both high: write only.
    while (m_count > 0) cycle("sim_drain", 1'b0, 1'b1, 8'h00, 1'b0);
    cycle("sim_empty", 1'b1, 1'b1, 8'h88, 1'b0);
    check("sim_empty.count", 32'(count), 32'd1);
    cycle("sim_pop", 1'b0, 1'b1, 8'h00, 1'b0);

    // Threshold boundaries: 0 forces almost_full, DEPTH forces almost_empty.
    for (int i = 0; i < 3; i++) cycle("th_fill", 1'b1, 1'b0, DW'(8'h40 + i), 1'b0);
    afull_thresh = 5'd0;
    cycle("th_afull0", 1'b0, 1'b0, 8'h00, 1'b0);
    check("th_afull0.flag", 32'(almost_full), 32'd1);
    aempty_thresh = 5'd16;
    cycle("th_aempty16", 1'b0, 1'b0, 8'h00, 1'b0);
    check("th_aempty16.flag", 32'(almost_empty), 32'd1);
    afull_thresh  = 5'd3;
    aempty_thresh = 5'd2;
    cycle("th_restore", 1'b0, 1'b0, 8'h00, 1'b0);
    while (m_count > 0) cycle("th_drain", 1'b0, 1'b1, 8'h00, 1'b0);
    afull_thresh = 5'd12;

    // Wrap: 40 accepted writes with random gaps and reads, then drain.
    writes = 0;
    for (int c = 0; c < 600 && (writes < 40 || m_count > 0); c++) begin
      pre = m_count;
      w   = (writes < 40) && ($urandom_range(0, 2) != 0);
      r   = ($urandom_range(0, 1) != 0);
      cycle("wrap", w, r, DW'($urandom), 1'b0);
      if (w && pre < DEPTH) writes++;
    end
    check("wrap.writes", 32'(writes), 32'd40);
    check("wrap.drained", 32'(count), 32'd0);
    cycle("wrap_clr", 1'b0, 1'b0, 8'h00, 1'b1);

    // Reset mid-operation at count 9 with underflow pending.
    cycle("rst_unf", 1'b0, 1'b1, 8'h00, 1'b0);
    for (int i = 0; i < 9; i++) cycle("rst_fill", 1'b1, 1'b0, DW'(8'h60 + i), 1'b0);
    check("rst_pre.count", 32'(count), 32'd9);
    #2 rst = 1'b1;
    model_reset();
    #1;
    check_state("rst_async");
    @(negedge clk);
    rst = 1'b0;
    cycle("rst_recover_w", 1'b1, 1'b0, 8'h5A, 1'b0);
    cycle("rst_recover_r", 1'b0, 1'b1, 8'h00, 1'b0);

    // Single word through an empty FIFO.
    cycle("a5_write", 1'b1, 1'b0, 8'hA5, 1'b0);
`ifdef SYNC_FIFO_FWFT_EN
    check("fwft.rdata", 32'(rdata), 32'hA5);
    check("fwft.rempty", 32'(rempty), 32'd0);
    cycle("a5_pop", 1'b0, 1'b1, 8'h00, 1'b0);
    check("fwft.rempty_after", 32'(rempty), 32'd1);
`else
    cycle("a5_read", 1'b0, 1'b1, 8'h00, 1'b0);
    check("std.rdata", 32'(rdata), 32'hA5);
    cycle("a5_hold", 1'b0, 1'b0, 8'h00, 1'b0);
    check("std.rdata_hold", 32'(rdata), 32'hA5);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
